// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared definitions for the two-requester data-memory bus controller:
//   FSM state encodings, grant identifiers, and the SCPU dm_ctrl access-type
//   encodings carried through the bus unchanged.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        MB_IDLE   = 2'd0,
        MB_ACCESS = 2'd1,
        MB_DONE   = 2'd2
    } mb_state_t;

    // Grant identifiers; also the encoding of the last_grant register.
    localparam logic MB_GNT_CPU = 1'b0;
    localparam logic MB_GNT_DMA = 1'b1;

    // SCPU dm_ctrl access types (same values as the core's control encodings).
    localparam logic [2:0] DM_WORD              = 3'b000;
    localparam logic [2:0] DM_HALFWORD          = 3'b001;
    localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
    localparam logic [2:0] DM_BYTE              = 3'b011;
    localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// rr_arb2
//   Combinational two-way round-robin grant. On a tie the requester that did
//   not win last time is chosen; a lone requester always wins. The
//   last_grant register lives in the parent.
//   Ports:
//     cpu_req, dma_req  in   request lines
//     last_grant        in   id of the previous winner (0 = CPU, 1 = DMA)
//     gnt_valid         out  at least one request present
//     gnt_id            out  id of the winner (meaningful when gnt_valid)
module rr_arb2
    import mem_bus_arbiter_pkg::*;
(
    input  logic cpu_req,
    input  logic dma_req,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_id
);

    always_comb begin
        gnt_valid = cpu_req | dma_req;
        gnt_id    = MB_GNT_CPU;
        if (cpu_req && dma_req) begin
            gnt_id = ~last_grant;
        end else if (dma_req) begin
            gnt_id = MB_GNT_DMA;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Data-memory bus controller shared by the SCPU data port and a DMA/debug
//   master. A round-robin winner is chosen in IDLE and its request latched;
//   the memory is then accessed for WAIT_CYC+1 cycles (ACCESS), after which
//   the winner receives a one-cycle ready pulse (DONE).
//   Ports:
//     clk, reset                       clock, synchronous active-high reset
//     cpu_req/we/addr/wdata/dmtype     CPU request
//     cpu_rdata, cpu_ready             CPU load data and completion pulse
//     dma_req/we/addr/wdata/dmtype     DMA request
//     dma_rdata, dma_ready             DMA load data and completion pulse
//     mem_en/we/addr/wdata/dmtype      memory access, driven only in ACCESS
//     mem_rdata                        memory read data, valid on last access cycle
//     busy                             high in ACCESS and DONE
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [2:0]        cpu_dmtype,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [DATA_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic [2:0]        dma_dmtype,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_dmtype,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [2:0] LAST_CNT = 3'(WAIT_CYC);

    mb_state_t         state;
    mb_state_t         state_nxt;
    logic [2:0]        cnt;
    logic              gnt_q;
    logic              last_grant;
    logic              we_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        dmtype_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;
    logic              gnt_valid;
    logic              gnt_id;
    logic              take;
    logic              last_acc;

    rr_arb2 u_rr_arb2 (
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign take     = (state == MB_IDLE) && gnt_valid;
    assign last_acc = (state == MB_ACCESS) && (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_dmtype = '0;
        cpu_ready  = 1'b0;
        dma_ready  = 1'b0;
        busy       = 1'b0;
        case (state)
            MB_IDLE: begin
                if (gnt_valid) begin
                    state_nxt = MB_ACCESS;
                end
            end
            MB_ACCESS: begin
                // Bus is driven purely from the latched request, so requester
                // inputs may change freely while the access is in flight.
                mem_en     = 1'b1;
                mem_we     = we_q;
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
                mem_dmtype = dmtype_q;
                busy       = 1'b1;
                if (cnt == LAST_CNT) begin
                    state_nxt = MB_DONE;
                end
            end
            MB_DONE: begin
                busy      = 1'b1;
                cpu_ready = (gnt_q == MB_GNT_CPU);
                dma_ready = (gnt_q == MB_GNT_DMA);
                state_nxt = MB_IDLE;
            end
            default: begin
                state_nxt = MB_IDLE;
            end
        endcase
    end

    // Control: wait counter, grant owner and round-robin history.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= 3'd0;
            gnt_q      <= MB_GNT_CPU;
            last_grant <= MB_GNT_DMA;
        end else if (take) begin
            cnt        <= 3'd0;
            gnt_q      <= gnt_id;
            last_grant <= gnt_id;
        end else if (state == MB_ACCESS) begin
            cnt <= cnt + 3'd1;
        end
    end

    // Latched request; only observable through the bus during ACCESS.
    always_ff @(posedge clk) begin
        if (take) begin
            we_q     <= gnt_id ? dma_we     : cpu_we;
            addr_q   <= gnt_id ? dma_addr   : cpu_addr;
            wdata_q  <= gnt_id ? dma_wdata  : cpu_wdata;
            dmtype_q <= gnt_id ? dma_dmtype : cpu_dmtype;
        end
    end

    // Per-requester load data; held until that requester's next read ends.
    // Reset wins over a capture on the same edge, aborting the access.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else if (last_acc && !we_q) begin
            if (gnt_q == MB_GNT_CPU) begin
                cpu_rdata_q <= mem_rdata;
            end else begin
                dma_rdata_q <= mem_rdata;
            end
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter (WAIT_CYC=1 main instance plus a
//   WAIT_CYC=0 instance). Expected ready pulses are queued by the stimulus
//   and consumed by a negedge monitor.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
    logic [2:0]  cpu_dmtype = 0, dma_dmtype = 0;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ready, dma_ready, mem_en, mem_we, busy;
    logic [2:0]  mem_dmtype;

    logic        z_cpu_req = 0, z_cpu_we = 0, z_dma_req = 0, z_dma_we = 0;
    logic [31:0] z_cpu_addr = 0, z_cpu_wdata = 0, z_dma_addr = 0, z_dma_wdata = 0;
    logic [2:0]  z_cpu_dmtype = 0, z_dma_dmtype = 0;
    logic [31:0] z_cpu_rdata, z_dma_rdata, z_mem_addr, z_mem_wdata;
    logic [31:0] z_mem_rdata = 32'hDEAD_BEEF;
    logic        z_cpu_ready, z_dma_ready, z_mem_en, z_mem_we, z_busy;
    logic [2:0]  z_mem_dmtype;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        bit          is_dma;
        int          cyc;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    mem_bus_arbiter #(.DATA_W(32), .WAIT_CYC(1)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_dmtype(cpu_dmtype),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_dmtype(dma_dmtype),
        .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_dmtype(mem_dmtype),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_bus_arbiter #(.DATA_W(32), .WAIT_CYC(0)) u_dut_w0 (
        .clk(clk), .reset(reset),
        .cpu_req(z_cpu_req), .cpu_we(z_cpu_we), .cpu_addr(z_cpu_addr),
        .cpu_wdata(z_cpu_wdata), .cpu_dmtype(z_cpu_dmtype),
        .cpu_rdata(z_cpu_rdata), .cpu_ready(z_cpu_ready),
        .dma_req(z_dma_req), .dma_we(z_dma_we), .dma_addr(z_dma_addr),
        .dma_wdata(z_dma_wdata), .dma_dmtype(z_dma_dmtype),
        .dma_rdata(z_dma_rdata), .dma_ready(z_dma_ready),
        .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr),
        .mem_wdata(z_mem_wdata), .mem_dmtype(z_mem_dmtype),
        .mem_rdata(z_mem_rdata), .busy(z_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word memory model: preset contents at 0x10/0x14, writes tracked.
    logic [31:0] mem [0:63];
    logic        mem_wr [0:63];

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem[mem_addr[7:2]]    <= mem_wdata;
            mem_wr[mem_addr[7:2]] <= 1'b1;
        end
    end

    function automatic logic [31:0] init_val(input logic [31:0] a);
        case (a[7:0])
            8'h10:   return 32'hDEAD_BEEF;
            8'h14:   return 32'h0BAD_F00D;
            default: return 32'h0;
        endcase
    endfunction

    always_comb begin
        mem_rdata = init_val(mem_addr);
        if (mem_wr[mem_addr[7:2]] === 1'b1) mem_rdata = mem[mem_addr[7:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard monitor: every ready pulse must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (cpu_ready || dma_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", {30'd0, dma_ready, cpu_ready}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ready_who", {30'd0, dma_ready, cpu_ready}, e.is_dma ? 32'd2 : 32'd1);
                chk("ready_cycle", 32'(cyc), 32'(e.cyc));
                chk("ready_rdata", e.is_dma ? dma_rdata : cpu_rdata, e.rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic exp_t mk(input bit d, input int c, input logic [31:0] r);
        exp_t e;
        e.is_dma = d;
        e.cyc    = c;
        e.rdata  = r;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        do_reset();

        // Reset state
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_dma_ready", dma_ready, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);

        // CPU read only
        t = cyc;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_dmtype = 3'b000;
        sb.push_back(mk(0, t + 3, 32'hDEAD_BEEF));
        tick();
        cpu_req = 0;
        chk("rd_mem_en_c1", mem_en, 1);
        chk("rd_mem_addr", mem_addr, 32'h10);
        chk("rd_mem_we", mem_we, 0);
        chk("rd_busy", busy, 1);
        tick();
        chk("rd_mem_en_c2", mem_en, 1);
        tick();
        chk("rd_mem_en_done", mem_en, 0);
        chk("rd_busy_done", busy, 1);
        tick();
        chk("rd_busy_idle", busy, 0);

        // Tie after reset: CPU, DMA, CPU
        do_reset();
        t = cyc;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        dma_req = 1; dma_we = 0; dma_addr = 32'h14;
        sb.push_back(mk(0, t + 3, 32'hDEAD_BEEF));
        sb.push_back(mk(1, t + 7, 32'h0BAD_F00D));
        sb.push_back(mk(0, t + 11, 32'hDEAD_BEEF));
        repeat (9) tick();
        cpu_req = 0; dma_req = 0;
        repeat (4) tick();
        chk("tie_busy_end", busy, 0);

        // DMA write with address/data changing during ACCESS
        t = cyc;
        dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'h1234_5678;
        dma_dmtype = 3'b010;
        sb.push_back(mk(1, t + 3, 32'h0BAD_F00D));
        tick();
        dma_req = 0; dma_addr = 32'h99; dma_wdata = 32'hFFFF_FFFF;
        chk("wr_mem_addr_c1", mem_addr, 32'h20);
        chk("wr_mem_wdata_c1", mem_wdata, 32'h1234_5678);
        chk("wr_mem_we_c1", mem_we, 1);
        chk("wr_mem_dmtype", mem_dmtype, 3'b010);
        tick();
        chk("wr_mem_addr_c2", mem_addr, 32'h20);
        chk("wr_mem_we_c2", mem_we, 1);
        tick();
        chk("wr_mem_we_done", mem_we, 0);
        chk("wr_mem_en_done", mem_en, 0);
        tick();
        dma_dmtype = 3'b000; dma_we = 0;

        // CPU write request pulsed for one cycle
        t = cyc;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h24; cpu_wdata = 32'hCAFE_F00D;
        sb.push_back(mk(0, t + 3, 32'hDEAD_BEEF));
        tick();
        cpu_req = 0;
        chk("pulse_mem_en", mem_en, 1);
        repeat (3) tick();
        chk("pulse_no_second_c4", mem_en, 0);
        tick();
        chk("pulse_no_second_c5", mem_en, 0);
        chk("pulse_busy_c5", busy, 0);

        // Read both writes back; CPU won last, so the DMA wins this tie
        t = cyc;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h24;
        dma_req = 1; dma_we = 0; dma_addr = 32'h20;
        sb.push_back(mk(1, t + 3, 32'h1234_5678));
        sb.push_back(mk(0, t + 7, 32'hCAFE_F00D));
        tick();
        dma_req = 0;
        repeat (4) tick();
        cpu_req = 0;
        repeat (4) tick();

        // Reset in the second ACCESS cycle
        t = cyc;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        tick();
        cpu_req = 0;
        tick();
        reset = 1;
        tick();
        reset = 0;
        chk("rst_mid_mem_en", mem_en, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_cpu_ready", cpu_ready, 0);
        chk("rst_mid_cpu_rdata", cpu_rdata, 0);
        chk("rst_mid_mem_addr", mem_addr, 0);
        t = cyc;
        cpu_req = 1; cpu_addr = 32'h10;
        dma_req = 1; dma_addr = 32'h14;
        sb.push_back(mk(0, t + 3, 32'hDEAD_BEEF));
        tick();
        cpu_req = 0; dma_req = 0;
        repeat (4) tick();
        chk("rst_mid_busy_end", busy, 0);
        chk("rst_mid_dma_rdata", dma_rdata, 0);

        // WAIT_CYC=0 instance: single CPU read
        t = cyc;
        z_cpu_req = 1; z_cpu_we = 0; z_cpu_addr = 32'h10;
        tick();
        z_cpu_req = 0;
        chk("w0_mem_en_c1", z_mem_en, 1);
        chk("w0_mem_addr", z_mem_addr, 32'h10);
        chk("w0_ready_c1", z_cpu_ready, 0);
        tick();
        chk("w0_mem_en_c2", z_mem_en, 0);
        chk("w0_ready_c2", z_cpu_ready, 1);
        chk("w0_cpu_rdata", z_cpu_rdata, 32'hDEAD_BEEF);
        chk("w0_dma_ready", z_dma_ready, 0);
        tick();
        chk("w0_ready_c3", z_cpu_ready, 0);

        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-requester data-memory bus controller between the SCPU data port (mem_w / Addr_out / Data_out / dm_ctrl / MIO_ready) and the single-port data memory.
- The second requester is a DMA/debug master.
- Arbitrates fairly (round-robin), latches the winning request, and sequences a fixed wait-state memory access.
- Returns read data with a one-cycle ready pulse; the CPU stalls on ready low.

Parameters:
- DATA_W, 32, data and address width.
- WAIT_CYC, 1, extra memory wait states per access. Legal range 0..7; access phase lasts WAIT_CYC+1 cycles.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  CPU write enable (SCPU mem_w).
- cpu_addr  in  32  CPU byte address (SCPU Addr_out).
- cpu_wdata  in  32  CPU store data.
- cpu_dmtype  in  3  CPU access size/sign (SCPU dm_ctrl encoding).
- cpu_rdata  out  32  CPU load data.
- cpu_ready  out  1  CPU access complete (to MIO_ready).
- dma_req, dma_we, dma_addr, dma_wdata, dma_dmtype  in  1/1/32/32/3  DMA request, same meaning as the CPU inputs.
- dma_rdata  out  32  DMA load data.
- dma_ready  out  1  DMA access complete.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_dmtype  out  3  memory access type.
- mem_rdata  in  32  memory read data, valid on the last access cycle.
- busy  out  1  high in ACCESS and DONE.

Behaviour:
- Reset (synchronous, sampled at rising clk):
  - State IDLE, all outputs 0, both rdata registers 0, wait counter 0.
  - last_grant = DMA, so the CPU wins the first tie.
- IDLE:
  - If any req is high, grant and latch the winner's we/addr/wdata/dmtype into internal registers; next state ACCESS, counter=0.
  - Tie: grant the requester that is not last_grant, then update last_grant.
  - Single requester: that requester wins.
  - No req: stay in IDLE.
- ACCESS:
  - mem_en=1; mem_we/addr/wdata/dmtype are driven from the latched registers only; requester input changes are ignored.
  - Counter increments each cycle (3-bit).
  - When counter==WAIT_CYC, capture mem_rdata into the granted requester's rdata register (reads only; writes leave rdata unchanged). Next state DONE.
- DONE:
  - Granted requester's ready=1 for exactly one cycle; mem_en=0. Next state IDLE.
  - The other requester's ready stays 0.
- mem_en and mem_we are 0 outside ACCESS; mem_we is never 1 without mem_en.
- Latency: req high in IDLE at cycle t gives ready at cycle t+WAIT_CYC+2 (t+3 for the default). Back-to-back issue rate is one access per WAIT_CYC+3 cycles.
- A req high in IDLE is always a new request. A requester that keeps req high after its ready is re-arbitrated.
- rdata holds its value until that requester's next read completes.
- Req deasserted during ACCESS: the access still completes and ready still pulses. Writes are never cancelled.
- Other requester asserting req during ACCESS/DONE: it waits and is arbitrated in the next IDLE. Starvation-free: worst-case wait is one foreign access.
- Reset during ACCESS/DONE: the access is aborted at the reset edge, no ready pulse is issued, and mem_en is 0 from the next cycle.
- Undefined dmtype values are passed through unchanged; the arbiter does not decode them.

Decomposition:
- Shared header mem_bus_def.v, in the same style as ctrl_encode_def.v:
  - State encodings `MB_IDLE / `MB_ACCESS / `MB_DONE.
  - Grant IDs `MB_GNT_CPU=0, `MB_GNT_DMA=1.
  - dm_ctrl access-type constants, reused from the existing control encodings.
- One sub-module, rr_arb2: combinational 2-way round-robin grant from {cpu_req, dma_req, last_grant}; last_grant register in the parent.

Test Plan:
- CPU read only: cpu_req=1, we=0, addr=0x10, memory returns 0xDEADBEEF → mem_en high cycles 1–2, cpu_ready pulse at cycle 3, cpu_rdata=0xDEADBEEF, dma_ready=0 throughout.
- Tie after reset: both req=1 from cycle 0 and held → CPU granted first (ready at cycle 3), DMA next (dma_ready at cycle 7), then CPU again at cycle 11.
- Latching: DMA write addr=0x20, wdata=0x12345678; DMA changes addr to 0x99 during ACCESS → mem_addr stays 0x20, mem_we=1 only during ACCESS, dma_rdata unchanged.
- Req dropped mid-access: cpu_req pulsed for 1 cycle (write) → full ACCESS still runs, cpu_ready pulses once, no second access starts.
- Reset mid-access: assert reset in the second ACCESS cycle → next cycle all outputs 0, no ready pulse, state IDLE; subsequent CPU request wins the tie.
- WAIT_CYC=0 build: single CPU read → mem_en high for 1 cycle, ready at cycle 2.
